// File: rtl/secret_pkg.sv
// Shared constants and state encoding for the secret_loader display frame loader.
package secret_pkg;

    localparam int WORD_W     = 7;
    localparam int WORD_COUNT = 20;

    // Word sent to the display once a frame has been pushed out; it is also
    // the one host word value that is reserved and may not be stored.
    localparam logic [WORD_W-1:0] CMD_PLAY = 7'h7F;
    localparam logic [WORD_W-1:0] BLANK    = 7'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PLAY = 2'd2
    } state_t;

endpackage

// File: rtl/secret_loader_if.sv
// Host-side word stream and display-side outputs of secret_loader.
interface secret_loader_if #(
    parameter int WORD_W = 7
);

    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              stop;
    logic [WORD_W-1:0] dout;
    logic              busy;
    logic              playing;
    logic              err;

    // Host / testbench side
    modport master (
        output in_data, in_valid, in_last, stop,
        input  in_ready, dout, busy, playing, err
    );

    // Loader side
    modport slave (
        input  in_data, in_valid, in_last, stop,
        output in_ready, dout, busy, playing, err
    );

endinterface

// File: rtl/secret_word_buf.sv
// Frame storage: one synchronous write port, one combinational read port.
// Contents are not reset; the loader only reads locations it has written
// during the current frame.
module secret_word_buf #(
    parameter int WORD_COUNT = 20,
    parameter int WORD_W     = 7,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [WORD_COUNT];

    // Write the accepted host word into its frame slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/secret_loader.sv
// secret_loader: collects up to WORD_COUNT host words into a frame buffer,
// streams the whole frame to the display (unused slots blank), then holds
// the play command until stopped.
// Optional build macro LOADER_SANITIZE_EN: a received reserved word (7'h7F)
// is stored as blank and raises the sticky err flag. Without it, words are
// stored as received and err stays low.
import secret_pkg::*;

module secret_loader #(
    parameter int WORD_COUNT = secret_pkg::WORD_COUNT,
    parameter int WORD_W     = secret_pkg::WORD_W
) (
    input  logic           clk,
    input  logic           rst,
    secret_loader_if.slave bus
);

    localparam int CNT_W = $clog2(WORD_COUNT + 1);
    localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

    localparam logic [WORD_W-1:0] W_PLAY  = WORD_W'(CMD_PLAY);
    localparam logic [WORD_W-1:0] W_BLANK = WORD_W'(BLANK);

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic [WORD_W-1:0] dout_q, dout_n;
    logic [WORD_W-1:0] wdata, rdata;
    logic              we;
    logic              accept;
    logic              ready;

`ifdef LOADER_SANITIZE_EN
    logic              err_q, err_n;
`endif

    assign ready  = (state_q == IDLE) && (count_q < CNT_W'(WORD_COUNT));
    assign accept = ready && bus.in_valid;

    secret_word_buf #(
        .WORD_COUNT (WORD_COUNT),
        .WORD_W     (WORD_W),
        .ADDR_W     (IDX_W)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (count_q[IDX_W-1:0]),
        .wdata (wdata),
        .raddr (idx_q),
        .rdata (rdata)
    );

    // State, counters and the registered display word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            dout_q  <= W_BLANK;
`ifdef LOADER_SANITIZE_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            idx_q   <= idx_n;
            dout_q  <= dout_n;
`ifdef LOADER_SANITIZE_EN
            err_q   <= err_n;
`endif
        end
    end

    // Next-state, buffer write and next display word
    always_comb begin
        state_n = state_q;
        count_n = count_q;
        idx_n   = idx_q;
        dout_n  = dout_q;
        we      = 1'b0;
        wdata   = bus.in_data;
`ifdef LOADER_SANITIZE_EN
        err_n   = err_q;
        if (bus.in_data == W_PLAY) begin
            wdata = W_BLANK;
        end
`endif
        case (state_q)
            IDLE: begin
                dout_n = W_BLANK;
                idx_n  = '0;
                if (accept) begin
                    we      = 1'b1;
                    count_n = count_q + CNT_W'(1);
`ifdef LOADER_SANITIZE_EN
                    if (bus.in_data == W_PLAY) begin
                        err_n = 1'b1;
                    end
`endif
                    // A full buffer closes the frame even without in_last
                    if (bus.in_last || (count_n == CNT_W'(WORD_COUNT))) begin
                        state_n = SEND;
                    end
                end
            end
            SEND: begin
                dout_n = (CNT_W'(idx_q) < count_q) ? rdata : W_BLANK;
                if (idx_q == IDX_W'(WORD_COUNT - 1)) begin
                    state_n = PLAY;
                    idx_n   = '0;
                end else begin
                    idx_n = idx_q + IDX_W'(1);
                end
            end
            PLAY: begin
                dout_n = W_PLAY;
                if (bus.stop) begin
                    state_n = IDLE;
                    count_n = '0;
                    dout_n  = W_BLANK;
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
                idx_n   = '0;
                dout_n  = W_BLANK;
            end
        endcase
    end

    assign bus.in_ready = ready;
    assign bus.dout     = dout_q;
    assign bus.busy     = (state_q == SEND) || (state_q == PLAY);
    assign bus.playing  = (state_q == PLAY);
`ifdef LOADER_SANITIZE_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_secret_loader.sv
// Self-checking bench for secret_loader: frames are loaded, the expected
// display stream is queued at load time and compared word by word.
module tb_secret_loader;

    localparam int WC = 20;

    logic clk;
    logic rst;

    secret_loader_if #(.WORD_W(7)) bus ();

    secret_loader #(
        .WORD_COUNT (WC),
        .WORD_W     (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] frame_q[$];
    logic [6:0] exp_q[$];
    logic       exp_err = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] stored(input logic [6:0] w);
`ifdef LOADER_SANITIZE_EN
        return (w == 7'h7F) ? 7'h00 : w;
`else
        return w;
`endif
    endfunction

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        checks++;
        if (bus.dout !== 7'h00 || bus.busy !== 1'b0 || bus.playing !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: dout=%h busy=%b playing=%b in_ready=%b expected 00 0 0 1",
                     name, bus.dout, bus.busy, bus.playing, bus.in_ready);
        end
    endtask

    // Push frame_q into the DUT, queue the expected display stream
    task automatic load_frame(input bit use_last, input string name);
        int n;
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_ready[%0d]: got %b expected 1", name, i, bus.in_ready);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = frame_q[i];
            bus.in_last  = use_last && (i == n - 1);
            step();
`ifdef LOADER_SANITIZE_EN
            if (frame_q[i] == 7'h7F) exp_err = 1'b1;
`endif
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 7'h00;
        for (int i = 0; i < WC; i++) begin
            exp_q.push_back((i < n) ? stored(frame_q[i]) : 7'h00);
        end
        exp_q.push_back(7'h7F);
    endtask

    // Pop and compare one display word per cycle; optional stop pulse in SEND
    task automatic check_stream(input string name, input int stop_at, input int max_words);
        logic [6:0] e;
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < max_words) begin
            e = exp_q.pop_front();
            bus.stop = (i == stop_at);
            step();
            checks++;
            if (bus.dout !== e) begin
                errors++;
                $display("FAIL %s_dout[%0d]: got %h expected %h", name, i, bus.dout, e);
            end
            i++;
        end
        bus.stop = 1'b0;
    endtask

    task automatic do_stop(input string name);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk_idle(name);
        chk1({name, "_err"}, bus.err, exp_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset");
        chk1("reset_err", bus.err, 1'b0);
        exp_err = 1'b0;
    endtask

    task automatic test_full_frame();
        frame_q.delete();
        for (int i = 1; i <= WC; i++) frame_q.push_back(7'(i));
        load_frame(1'b0, "full");
        chk1("full_ready_after_20", bus.in_ready, 1'b0);
        chk1("full_busy", bus.busy, 1'b1);
        check_stream("full", -1, 1000);
        chk1("full_playing", bus.playing, 1'b1);
        do_stop("full_stop");
    endtask

    task automatic test_short_frame();
        frame_q.delete();
        frame_q.push_back(7'h41);
        frame_q.push_back(7'h42);
        frame_q.push_back(7'h43);
        load_frame(1'b1, "short");
        check_stream("short", -1, 1000);
        chk1("short_playing", bus.playing, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.dout !== 7'h7F) begin
                errors++;
                $display("FAIL short_hold[%0d]: got %h expected 7f", i, bus.dout);
            end
        end
        do_stop("short_stop");
    endtask

    task automatic test_reserved();
        frame_q.delete();
        frame_q.push_back(7'h05);
        frame_q.push_back(7'h7F);
        frame_q.push_back(7'h46);
        load_frame(1'b1, "resv");
        check_stream("resv", -1, 1000);
        chk1("resv_err", bus.err, exp_err);
        do_stop("resv_stop");
    endtask

    task automatic test_back_to_back();
        frame_q.delete();
        for (int i = 0; i < 6; i++) frame_q.push_back(7'h11 + 7'(i));
        load_frame(1'b1, "b2b_a");
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h55;
        bus.in_last  = 1'b1;
        for (int i = 0; i <= WC; i++) begin
            check_stream("b2b_a", -1, 1);
            chk1("b2b_ready_send", bus.in_ready, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("b2b_ready_play", bus.in_ready, 1'b0);
        end
        bus.stop = 1'b1;
        step();
        bus.stop     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk_idle("b2b_stop");
        frame_q.delete();
        frame_q.push_back(7'h21);
        frame_q.push_back(7'h22);
        load_frame(1'b1, "b2b_b");
        check_stream("b2b_b", -1, 1000);
        do_stop("b2b_b_stop");
    endtask

    task automatic test_stop_and_last();
        bus.in_last = 1'b1;
        bus.in_data = 7'h3C;
        step();
        step();
        bus.in_last = 1'b0;
        chk_idle("last_no_valid");
        frame_q.delete();
        frame_q.push_back(7'h31);
        frame_q.push_back(7'h32);
        frame_q.push_back(7'h33);
        frame_q.push_back(7'h34);
        load_frame(1'b1, "sts");
        check_stream("sts", 5, 1000);
        chk1("sts_playing", bus.playing, 1'b1);
        do_stop("sts_stop");
    endtask

    task automatic test_reset_abort();
        frame_q.delete();
        for (int i = 0; i < WC; i++) frame_q.push_back(7'h60 + 7'(i));
        load_frame(1'b0, "abort");
        check_stream("abort", -1, 10);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h7F;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 7'h00;
        exp_q.delete();
        exp_err = 1'b0;
        chk_idle("abort_rst");
        chk1("abort_err", bus.err, 1'b0);
        step();
        chk_idle("abort_after");
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_data  = 7'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.stop     = 1'b0;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_reserved();
        test_back_to_back();
        test_stop_and_last();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secret_loader.md
SECRET_LOADER -- requirements
Module: secret_loader

Interface
REQ-001 SHALL have parameter WORD_COUNT, default 20, giving the words per frame; it matches the display buffer depth.
REQ-002 SHALL have parameter WORD_W, default 7, giving the width of one display word.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_data  input  WORD_W  host word: bit6=0 is a raw 6-bit column, bit6=1 is a glyph code.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_last  input  1  qualifies in_valid; marks the final word of the frame.
REQ-008 SHALL have port in_ready  output  1  word accepted when in_valid&&in_ready.
REQ-009 SHALL have port stop  input  1  end the playback phase.
REQ-010 SHALL have port dout  output  WORD_W  registered word for the display din bus.
REQ-011 SHALL have port busy  output  1  high in SEND or PLAY.
REQ-012 SHALL have port playing  output  1  high in PLAY.
REQ-013 SHALL have port err  output  1  sticky flag for a reserved word received.

Function
REQ-014 SHALL implement a state machine with states IDLE, SEND and PLAY.
REQ-015 IDLE SHALL hold in_ready=1 while count<WORD_COUNT, store each accepted word at buffer[count], increment count and drive dout=7'h00.
REQ-016 Acceptance with in_last=1, or acceptance of word number WORD_COUNT, SHALL move to SEND on the next cycle.
REQ-017 SEND SHALL drive dout=buffer[i] for i<count and 7'h00 for count<=i<WORD_COUNT, one word per cycle, for exactly WORD_COUNT consecutive cycles with no gaps.
REQ-018 If the last word is accepted in cycle t, dout SHALL carry word0 at t+1, word(WORD_COUNT-1) at t+WORD_COUNT and 7'h7F from t+WORD_COUNT+1.
REQ-019 PLAY SHALL hold dout=7'h7F until stop=1; the next cycle SHALL then give IDLE, dout=7'h00, count=0 and err preserved.
REQ-020 in_ready SHALL be 0 in SEND and PLAY; in_valid there SHALL be ignored with no capture.
REQ-021 stop SHALL be ignored in IDLE and SEND.
REQ-022 in_last without in_valid SHALL have no effect.
REQ-023 count SHALL be ceil(log2(WORD_COUNT+1)) bits wide and never exceed WORD_COUNT.
REQ-024 The read index SHALL wrap to 0 on entering SEND.

Reset
REQ-025 rst SHALL force IDLE with count=0, index=0, dout=7'h00, in_ready=1, busy=0, playing=0 and err=0.
REQ-026 rst SHALL take priority over every input and SHALL abort SEND or PLAY mid-frame.
REQ-027 Buffer contents SHALL NOT need reset.

Configuration
REQ-028 With LOADER_SANITIZE_EN defined, an accepted in_data==7'h7F SHALL be stored as 7'h00 and SHALL set err.
REQ-029 Without LOADER_SANITIZE_EN, words SHALL be stored unmodified and err SHALL be tied to 0.

Structure
REQ-030 Package secret_pkg SHALL hold WORD_W, WORD_COUNT, CMD_PLAY=7'h7F, BLANK=7'h00 and the state enum.
REQ-031 The WORD_COUNT x WORD_W storage SHALL be sub-module secret_word_buf, with a synchronous write port and a combinational read port.

Verification
REQ-032 SHALL test: 20 words 0x01..0x14 with no in_last -> in_ready=0 after the 20th; dout 01..14 over the next 20 cycles, then 7F.
REQ-033 SHALL test: 41,42,43 with in_last on 43 -> dout 41,42,43, then 17 cycles of 00, then 7F; playing=1.
REQ-034 SHALL test: in_data=7F accepted -> with the macro, stored 00 and err=1; without it, 7F is sent and err=0.
REQ-035 SHALL test: in_valid=1 throughout SEND and PLAY -> in_ready=0 and the next frame's buffer holds only the new words.
REQ-036 SHALL test: rst asserted on SEND word 10 -> the next cycle gives dout=00, busy=0, in_ready=1 and err=0.
REQ-037 SHALL test: stop pulse in PLAY -> the next cycle gives dout=00 and busy=0; stop in SEND -> no effect and 7F still follows.
